// File: rtl/reg_move_pkg.sv
// rtl/reg_move_pkg.sv - shared state, move type and reset-value helper for the move sequencer
package reg_move_pkg;

  localparam int MOVE_IDXW = 2;

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_e;

  typedef struct packed {
    logic [MOVE_IDXW-1:0] src;
    logic [MOVE_IDXW-1:0] dst;
  } move_t;

  function automatic int init_val(input int i);
    return i + 1;
  endfunction

endpackage

// File: rtl/move_batch_buf.sv
// rtl/move_batch_buf.sv - append-only buffer of moves collected for one parallel batch
module move_batch_buf
  import reg_move_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = move_t,
  localparam int CNTW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_clear,
  input  entry_t          i_entry,
  output entry_t          o_entries [DEPTH],
  output logic [DEPTH-1:0] o_valid,
  output logic [CNTW-1:0] o_count,
  output logic            o_full
);

  entry_t            r_entries [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [CNTW-1:0]   r_count;

  assign o_entries = r_entries;
  assign o_valid   = r_valid;
  assign o_count   = r_count;
  assign o_full    = (r_count == CNTW'(DEPTH));

  // Entries keep arrival order so the commit stage can let later moves win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end else if (i_clear) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (i_push && !o_full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_count == CNTW'(i)) begin
          r_entries[i] <= i_entry;
          r_valid[i]   <= 1'b1;
        end
      end
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/reg_move_sequencer.sv
// rtl/reg_move_sequencer.sv - register file executing move batches in sequential or parallel commit mode
module reg_move_sequencer
  import reg_move_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  NREGS = 4,
  parameter int  DEPTH = 4,
  localparam int IDXW  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDXW-1:0]  cmd_src,
  input  logic [IDXW-1:0]  cmd_dst,
  input  logic             cmd_last,
  input  logic             cmd_mode,
  input  logic [IDXW-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             batch_done
);

  typedef struct packed {
    logic [IDXW-1:0] src;
    logic [IDXW-1:0] dst;
  } move_w_t;

  localparam int CNTW = $clog2(DEPTH + 1);

  state_e           r_state, w_next_state;
  logic             r_seq_mode;
  logic             r_done;
  logic [WIDTH-1:0] r_regs        [NREGS];
  logic [WIDTH-1:0] w_commit_regs [NREGS];

  move_w_t          w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [CNTW-1:0]  w_count;
  logic             w_full;
  logic             w_accept, w_seq, w_push, w_seq_wr, w_last_eff;

  function automatic logic in_range(input logic [IDXW-1:0] idx);
    return {1'b0, idx} < (IDXW + 1)'(NREGS);
  endfunction

  assign cmd_ready  = (r_state != COMMIT);
  assign busy       = (r_state != IDLE);
  assign batch_done = r_done;
  assign rd_data    = in_range(rd_idx) ? r_regs[rd_idx] : '0;

  // Mode comes from the command only on the opening move of a batch.
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_seq      = (r_state == IDLE) ? cmd_mode : r_seq_mode;
  assign w_push     = w_accept & ~w_seq & ~w_full;
  assign w_seq_wr   = w_accept & w_seq & in_range(cmd_src) & in_range(cmd_dst);
  assign w_last_eff = cmd_last | (w_count == CNTW'(DEPTH - 1));

  move_batch_buf #(
    .DEPTH   (DEPTH),
    .entry_t (move_w_t)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_clear   (r_state == COMMIT),
    .i_entry   ('{src: cmd_src, dst: cmd_dst}),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_count   (w_count),
    .o_full    (w_full)
  );

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE, COLLECT: begin
        if (w_accept) begin
          if (w_seq) w_next_state = cmd_last ? IDLE : COLLECT;
          else       w_next_state = w_last_eff ? COMMIT : COLLECT;
        end
      end
      COMMIT:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Every source reads the pre-commit file; scanning upward lets the later entry win a shared dst.
  always_comb begin
    w_commit_regs = r_regs;
    for (int e = 0; e < DEPTH; e++) begin
      if (w_valid[e] && in_range(w_entries[e].src) && in_range(w_entries[e].dst))
        w_commit_regs[w_entries[e].dst] = r_regs[w_entries[e].src];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_seq_mode <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_accept) r_seq_mode <= cmd_mode;
      r_done <= (r_state == COMMIT) | (w_accept & w_seq & cmd_last);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= WIDTH'(init_val(i));
    end else if (r_state == COMMIT) begin
      r_regs <= w_commit_regs;
    end else if (w_seq_wr) begin
      r_regs[cmd_dst] <= r_regs[cmd_src];
    end
  end

endmodule

// File: tb/tb_reg_move_sequencer.sv
// tb/tb_reg_move_sequencer.sv - scenario and randomized checks of reg_move_sequencer against an array model
module tb_reg_move_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_last = 1'b0;
  logic        cmd_mode = 1'b0;
  logic [1:0]  cmd_src = '0;
  logic [1:0]  cmd_dst = '0;
  logic [1:0]  rd_idx = '0;
  logic        cmd_ready, busy, batch_done;
  logic [31:0] rd_data;

  int pass_cnt = 0;
  int total = 0;
  int m [4];

  always #10 clk = ~clk;

  reg_move_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_last   (cmd_last),
    .cmd_mode   (cmd_mode),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .busy       (busy),
    .batch_done (batch_done)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = i + 1;
  endtask

  task automatic model_seq(input int s, input int d);
    m[d] = m[s];
  endtask

  task automatic model_par(input int ss[$], input int dd[$]);
    int snap [4];
    snap = m;
    foreach (ss[k]) m[dd[k]] = snap[ss[k]];
  endtask

  task automatic read_reg(input int i, output logic [31:0] v);
    rd_idx = 2'(i);
    #1;
    v = rd_data;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drive_move(input int s, input int d, input bit last, input bit mode);
    cmd_src   = 2'(s);
    cmd_dst   = 2'(d);
    cmd_last  = last;
    cmd_mode  = mode;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      total++;
      if (v !== 32'(i + 1)) $display("FAIL reset_reg%0d: got %0d expected %0d", i, v, i + 1);
      else pass_cnt++;
    end
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total++;
    if (batch_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", batch_done); else pass_cnt++;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_parallel_basic();
    logic [31:0] v;
    do_reset();
    drive_move(1, 0, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b1 || cmd_ready !== 1'b1)
      $display("FAIL par_collect_flags: got busy=%b ready=%b expected busy=1 ready=1", busy, cmd_ready);
    else pass_cnt++;
    read_reg(0, v);
    total++;
    if (v !== 32'(m[0])) $display("FAIL par_no_early_write: got %0d expected %0d", v, m[0]); else pass_cnt++;
    drive_move(0, 2, 1'b1, 1'b0);
    total++;
    if (cmd_ready !== 1'b0 || batch_done !== 1'b0)
      $display("FAIL par_commit_flags: got ready=%b done=%b expected ready=0 done=0", cmd_ready, batch_done);
    else pass_cnt++;
    read_reg(2, v);
    total++;
    if (v !== 32'(m[2])) $display("FAIL par_commit_pending: got %0d expected %0d", v, m[2]); else pass_cnt++;
    model_par('{1, 0}, '{0, 2});
    @(posedge clk);
    #1;
    total++;
    if (batch_done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL par_done_flags: got done=%b ready=%b busy=%b expected 1 1 0", batch_done, cmd_ready, busy);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      total++;
      if (v !== 32'(m[i])) $display("FAIL par_basic_reg%0d: got %0d expected %0d", i, v, m[i]);
      else pass_cnt++;
    end
    @(posedge clk);
    #1;
    total++;
    if (batch_done !== 1'b0) $display("FAIL par_done_width: got %b expected 0", batch_done); else pass_cnt++;
  endtask

  task automatic test_sequential_basic();
    logic [31:0] v;
    do_reset();
    drive_move(1, 0, 1'b0, 1'b1);
    model_seq(1, 0);
    read_reg(0, v);
    total++;
    if (v !== 32'(m[0])) $display("FAIL seq_edge1_reg0: got %0d expected %0d", v, m[0]); else pass_cnt++;
    total++;
    if (busy !== 1'b1 || batch_done !== 1'b0)
      $display("FAIL seq_edge1_flags: got busy=%b done=%b expected 1 0", busy, batch_done);
    else pass_cnt++;
    drive_move(0, 2, 1'b1, 1'b0);
    model_seq(0, 2);
    read_reg(2, v);
    total++;
    if (v !== 32'(m[2])) $display("FAIL seq_edge2_reg2: got %0d expected %0d", v, m[2]); else pass_cnt++;
    total++;
    if (batch_done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL seq_done_flags: got done=%b busy=%b ready=%b expected 1 0 1", batch_done, busy, cmd_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total++;
    if (batch_done !== 1'b0) $display("FAIL seq_done_width: got %b expected 0", batch_done); else pass_cnt++;
  endtask

  task automatic test_swap();
    logic [31:0] v;
    do_reset();
    drive_move(1, 0, 1'b0, 1'b0);
    drive_move(0, 1, 1'b1, 1'b0);
    model_par('{1, 0}, '{0, 1});
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      read_reg(i, v);
      total++;
      if (v !== 32'(m[i])) $display("FAIL par_swap_reg%0d: got %0d expected %0d", i, v, m[i]);
      else pass_cnt++;
    end
    do_reset();
    drive_move(1, 0, 1'b0, 1'b1);
    model_seq(1, 0);
    drive_move(0, 1, 1'b1, 1'b1);
    model_seq(0, 1);
    for (int i = 0; i < 2; i++) begin
      read_reg(i, v);
      total++;
      if (v !== 32'(m[i])) $display("FAIL seq_swap_reg%0d: got %0d expected %0d", i, v, m[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_depth_dup();
    logic [31:0] v;
    do_reset();
    drive_move(0, 3, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || cmd_ready !== 1'b1)
      $display("FAIL depth_gap_flags: got busy=%b ready=%b expected 1 1", busy, cmd_ready);
    else pass_cnt++;
    drive_move(1, 3, 1'b0, 1'b1);
    drive_move(2, 0, 1'b0, 1'b0);
    drive_move(3, 1, 1'b0, 1'b0);
    total++;
    if (cmd_ready !== 1'b0) $display("FAIL depth_auto_commit: got ready=%b expected 0", cmd_ready); else pass_cnt++;
    model_par('{0, 1, 2, 3}, '{3, 3, 0, 1});
    @(posedge clk);
    #1;
    total++;
    if (batch_done !== 1'b1) $display("FAIL depth_done: got %b expected 1", batch_done); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      total++;
      if (v !== 32'(m[i])) $display("FAIL depth_dup_reg%0d: got %0d expected %0d", i, v, m[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    bit seen_done;
    do_reset();
    drive_move(1, 0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    model_reset();
    read_reg(0, v);
    total++;
    if (v !== 32'(m[0])) $display("FAIL rst_mid_seq_reg0: got %0d expected %0d", v, m[0]); else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_move(2, 1, 1'b0, 1'b0);
    drive_move(3, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    total++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL rst_mid_flags: got busy=%b ready=%b expected 0 1", busy, cmd_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (batch_done === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (seen_done) $display("FAIL rst_mid_no_done: got done pulse expected none"); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      total++;
      if (v !== 32'(m[i])) $display("FAIL rst_mid_reg%0d: got %0d expected %0d", i, v, m[i]);
      else pass_cnt++;
    end
    drive_move(3, 1, 1'b1, 1'b0);
    model_par('{3}, '{1});
    @(posedge clk);
    #1;
    read_reg(1, v);
    total++;
    if (batch_done !== 1'b1 || v !== 32'(m[1]))
      $display("FAIL rst_mid_next_batch: got done=%b reg1=%0d expected done=1 reg1=%0d", batch_done, v, m[1]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] v;
    int ss[$];
    int dd[$];
    int n, s, d;
    bit mode, last;
    do_reset();
    for (int b = 0; b < 30; b++) begin
      mode = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      ss.delete();
      dd.delete();
      for (int k = 0; k < n; k++) begin
        s = $urandom_range(0, 3);
        d = $urandom_range(0, 3);
        last = (k == n - 1) && (mode || n < 4 || ($urandom_range(0, 1) == 1));
        drive_move(s, d, last, (k == 0) ? mode : 1'($urandom_range(0, 1)));
        if (mode) begin
          model_seq(s, d);
          read_reg(d, v);
          total++;
          if (v !== 32'(m[d])) $display("FAIL rnd_seq_b%0d_m%0d: got %0d expected %0d", b, k, v, m[d]);
          else pass_cnt++;
        end else begin
          ss.push_back(s);
          dd.push_back(d);
        end
      end
      if (!mode) begin
        total++;
        if (cmd_ready !== 1'b0) $display("FAIL rnd_par_commit_b%0d: got ready=%b expected 0", b, cmd_ready);
        else pass_cnt++;
        model_par(ss, dd);
        @(posedge clk);
        #1;
      end
      total++;
      if (batch_done !== 1'b1) $display("FAIL rnd_done_b%0d: got %b expected 1", b, batch_done); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
        read_reg(i, v);
        total++;
        if (v !== 32'(m[i])) $display("FAIL rnd_b%0d_reg%0d: got %0d expected %0d", b, i, v, m[i]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_parallel_basic();
    test_sequential_basic();
    test_swap();
    test_depth_dup();
    test_reset_mid();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
